// File: rtl/uart_tx_scheduler.sv
//-----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Purpose:
//   Merges two sensor streams onto the single 56-bit word interface of the
//   UART controller. The streams are ADS1292 ECG frames (72 bits) and MPR121
//   touch status (12 bits).
//   - Each source has a one-entry holding buffer with a pending flag.
//   - Pending sources are granted round-robin.
//   - Each granted source is packed into a tagged 56-bit word and offered
//     with a valid/ready handshake.
//   Everything runs in the 25 MHz domain.
//
// Word formats:
//   ADS   : {ADS_TAG, ch1[23:0], ch2[23:0]}
//           The 24-bit status field of the frame is not forwarded.
//   Touch : {TCH_TAG, 4'h0, status[11:0], ads_drop_cnt[7:0], frame_cnt[23:0]}
//           frame_cnt counts accepted ADS words and wraps at 24 bits.
//
// Ports:
//   i_CLK          in   1   system clock (25 MHz)
//   i_RSTN         in   1   asynchronous active-low reset
//   i_RUN          in   1   capture enable; low drops captures and pendings
//   i_ADS_DATA     in  72   {status, ch1, ch2}
//   i_ADS_VALID    in   1   one-cycle capture strobe for i_ADS_DATA
//   i_TCH_STATUS   in  12   touch electrode status
//   i_TCH_VALID    in   1   one-cycle capture strobe for i_TCH_STATUS
//   o_TX_DATA      out 56   packed word toward the UART controller
//   o_TX_VALID     out  1   o_TX_DATA holds a word
//   i_TX_READY     in   1   UART controller accepts the word
//   o_ADS_DROP_CNT out  8   saturating count of overwritten ADS frames
//   o_BUSY         out  1   a word is in flight or a source is pending
//
// Build option:
//   UART_SCHED_TOUCH_CHANGE_EN
//     Defined:   a touch strobe only counts as a capture when the status
//                differs from the status in the last touch word loaded.
//                That reference value is 12'h000 after reset.
//     Undefined: every touch strobe counts as a capture.
//-----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter logic [7:0] ADS_TAG = 8'hA1,
    parameter logic [7:0] TCH_TAG = 8'hB2
) (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    input  logic        i_RUN,
    input  logic [71:0] i_ADS_DATA,
    input  logic        i_ADS_VALID,
    input  logic [11:0] i_TCH_STATUS,
    input  logic        i_TCH_VALID,
    output logic [55:0] o_TX_DATA,
    output logic        o_TX_VALID,
    input  logic        i_TX_READY,
    output logic [7:0]  o_ADS_DROP_CNT,
    output logic        o_BUSY
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    typedef enum logic {
        SRC_ADS = 1'b0,
        SRC_TCH = 1'b1
    } src_t;

    //-------------------------------------------------------------------------
    // Registered state
    //-------------------------------------------------------------------------
    state_t      state_reg;
    src_t        last_grant_reg;     // source of the word loaded most recently
    logic [47:0] ads_buf_reg;        // only ch1/ch2 are ever sent
    logic        ads_pend_reg;
    logic [11:0] tch_buf_reg;
    logic        tch_pend_reg;
    logic [55:0] tx_data_reg;
    logic        tx_valid_reg;
    logic [7:0]  drop_cnt_reg;
    logic [23:0] frame_cnt_reg;
`ifdef UART_SCHED_TOUCH_CHANGE_EN
    logic [11:0] tch_ref_reg;        // status carried by the last touch word
`endif

    //-------------------------------------------------------------------------
    // Decisions for the current cycle
    //-------------------------------------------------------------------------
    logic ads_cap;
    logic tch_cap;
    logic can_load;
    logic grant_ads;
    logic grant_tch;
    logic load_ads;
    logic load_tch;
    logic handshake;
    logic ads_drop;
    logic frame_inc;

    // The ADS status word never leaves the block.
    logic unused_ads_status;
    assign unused_ads_status = ^i_ADS_DATA[71:48];

    always_comb begin
        ads_cap = i_RUN & i_ADS_VALID;
`ifdef UART_SCHED_TOUCH_CHANGE_EN
        // A repeat of the last status sent is not news and is ignored.
        tch_cap = i_RUN & i_TCH_VALID & (i_TCH_STATUS != tch_ref_reg);
`else
        tch_cap = i_RUN & i_TCH_VALID;
`endif

        // With i_RUN low the pending flags are being flushed, so nothing
        // new is loaded. A word that is already in flight still completes.
        can_load = (state_reg == ST_IDLE) & i_RUN;

        // Round robin on a tie. A lone pending source always wins.
        grant_ads = ads_pend_reg & (~tch_pend_reg | (last_grant_reg == SRC_TCH));
        grant_tch = tch_pend_reg & ~grant_ads;

        load_ads = can_load & grant_ads;
        load_tch = can_load & grant_tch;

        handshake = (state_reg == ST_SEND) & tx_valid_reg & i_TX_READY;

        // An overwrite is only a loss when the old frame is not leaving on
        // the same edge.
        ads_drop = ads_cap & ads_pend_reg & ~load_ads;

        // The word in flight is the last granted one.
        frame_inc = handshake & (last_grant_reg == SRC_ADS);
    end

    //-------------------------------------------------------------------------
    // FSM, holding buffers, counters and output registers
    //-------------------------------------------------------------------------
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= SRC_TCH;  // ADS wins the first tie
            ads_buf_reg    <= '0;
            ads_pend_reg   <= 1'b0;
            tch_buf_reg    <= '0;
            tch_pend_reg   <= 1'b0;
            tx_data_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            drop_cnt_reg   <= '0;
            frame_cnt_reg  <= '0;
`ifdef UART_SCHED_TOUCH_CHANGE_EN
            tch_ref_reg    <= '0;
`endif
        end else begin
            // Pending flags.
            // A capture in the same cycle as a load of the same source
            // keeps the flag set, so the new data is sent next.
            if (!i_RUN) begin
                ads_pend_reg <= 1'b0;
                tch_pend_reg <= 1'b0;
            end else begin
                ads_pend_reg <= ads_cap | (ads_pend_reg & ~load_ads);
                tch_pend_reg <= tch_cap | (tch_pend_reg & ~load_tch);
            end

            // The buffers take new data on capture. A load on the same edge
            // reads the old contents, because this is a non-blocking update.
            if (ads_cap) begin
                ads_buf_reg <= i_ADS_DATA[47:0];
            end
            if (tch_cap) begin
                tch_buf_reg <= i_TCH_STATUS;
            end

            if (ads_drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end

            // The count wraps naturally at 24 bits.
            if (frame_inc) begin
                frame_cnt_reg <= frame_cnt_reg + 24'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (load_ads) begin
                        tx_data_reg    <= {ADS_TAG, ads_buf_reg};
                        tx_valid_reg   <= 1'b1;
                        last_grant_reg <= SRC_ADS;
                        state_reg      <= ST_SEND;
                    end else if (load_tch) begin
                        tx_data_reg    <= {TCH_TAG, 4'h0, tch_buf_reg,
                                           drop_cnt_reg, frame_cnt_reg};
                        tx_valid_reg   <= 1'b1;
                        last_grant_reg <= SRC_TCH;
                        state_reg      <= ST_SEND;
`ifdef UART_SCHED_TOUCH_CHANGE_EN
                        tch_ref_reg    <= tch_buf_reg;
`endif
                    end
                end

                ST_SEND: begin
                    // o_TX_DATA is held until the controller takes the word.
                    if (handshake) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg    <= ST_IDLE;
                    tx_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign o_TX_DATA      = tx_data_reg;
    assign o_TX_VALID     = tx_valid_reg;
    assign o_ADS_DROP_CNT = drop_cnt_reg;

    // Derived from registered state only.
    assign o_BUSY = (state_reg != ST_IDLE) | ads_pend_reg | tch_pend_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
//-----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Runs directed scenarios first, then randomized rounds.
// Expected words come from a transaction-level model of the scheduler:
//   - a queue of the words the scheduler should send
//   - which source was sent last
//   - the accepted-ADS frame count
//   - the ADS drop count
//   - the last touch status sent
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam logic [7:0] ADS_TAG = 8'hA1;
    localparam logic [7:0] TCH_TAG = 8'hB2;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        run        = 1'b0;
    logic [71:0] ads_data   = '0;
    logic        ads_valid  = 1'b0;
    logic [11:0] tch_status = '0;
    logic        tch_valid  = 1'b0;
    logic        tx_ready   = 1'b0;
    logic [55:0] tx_data;
    logic        tx_valid;
    logic [7:0]  drop_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_last_ads;
    logic [23:0] m_frame;
    logic [7:0]  m_drop;
    logic [11:0] m_ref;
    logic [55:0] exp_q[$];
    logic [55:0] got[$];

    uart_tx_scheduler dut (
        .i_CLK          (clk),
        .i_RSTN         (rst_n),
        .i_RUN          (run),
        .i_ADS_DATA     (ads_data),
        .i_ADS_VALID    (ads_valid),
        .i_TCH_STATUS   (tch_status),
        .i_TCH_VALID    (tch_valid),
        .o_TX_DATA      (tx_data),
        .o_TX_VALID     (tx_valid),
        .i_TX_READY     (tx_ready),
        .o_ADS_DROP_CNT (drop_cnt),
        .o_BUSY         (busy)
    );

    always #20 clk = ~clk;

    //-------------------------------------------------------------------------
    // Comparison helpers
    //-------------------------------------------------------------------------
    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check56(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    //-------------------------------------------------------------------------
    // Reference model
    //-------------------------------------------------------------------------
    function automatic logic [55:0] ads_word(input logic [71:0] a);
        return {ADS_TAG, a[47:0]};
    endfunction

    task automatic model_reset();
        m_last_ads = 1'b0;
        m_frame    = '0;
        m_drop     = '0;
        m_ref      = '0;
        exp_q.delete();
    endtask

    task automatic model_send_ads(input logic [71:0] a);
        exp_q.push_back(ads_word(a));
        m_frame    = m_frame + 24'd1;
        m_last_ads = 1'b1;
    endtask

    task automatic model_send_tch(input logic [11:0] t);
        bit send;
        send = 1'b1;
`ifdef UART_SCHED_TOUCH_CHANGE_EN
        send = (t != m_ref);
`endif
        if (send) begin
            exp_q.push_back({TCH_TAG, 4'h0, t, m_drop, m_frame});
            m_ref      = t;
            m_last_ads = 1'b0;
        end
    endtask

    // Both sources captured together while idle: the one not sent last
    // goes first.
    task automatic model_send_both(input logic [71:0] a, input logic [11:0] t);
        if (m_last_ads) begin
            model_send_tch(t);
            model_send_ads(a);
        end else begin
            model_send_ads(a);
            model_send_tch(t);
        end
    endtask

    //-------------------------------------------------------------------------
    // Stimulus helpers
    //-------------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        run       = 1'b0;
        ads_valid = 1'b0;
        tch_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        model_reset();
    endtask

    // Drives a one-cycle strobe.
    // Returns on the negedge just after the capturing posedge.
    task automatic pulse(input bit do_ads, input logic [71:0] a,
                         input bit do_tch, input logic [11:0] t);
        @(negedge clk);
        ads_data   = a;
        tch_status = t;
        ads_valid  = do_ads;
        tch_valid  = do_tch;
        @(negedge clk);
        ads_valid = 1'b0;
        tch_valid = 1'b0;
    endtask

    // Acts as the UART controller.
    // Collects accepted words into 'got' and checks that an unaccepted word
    // stays valid and unchanged. It stops after n words, or after max_cycles
    // (always the limit when n is 0).
    task automatic drain(input int n, input int max_cycles, input bit rnd);
        logic [55:0] held;
        bit          hold;
        hold = 1'b0;
        held = '0;
        got.delete();
        for (int c = 0; c < max_cycles && !(n > 0 && got.size() >= n); c++) begin
            @(negedge clk);
            if (hold) begin
                check1("valid_hold", tx_valid, 1'b1);
                check56("data_hold", tx_data, held);
            end
            tx_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                hold = 1'b0;
            end else if (tx_valid) begin
                hold = 1'b1;
                held = tx_data;
            end else begin
                hold = 1'b0;
            end
        end
    endtask

    // Compares the collected words with the model.
    // Then confirms nothing else is pending.
    task automatic compare(input string tag);
        checkn({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check56(tag, got[i], exp_q[i]);
        end
        exp_q.delete();
        @(negedge clk);
        check1({tag, "_idle"}, busy, 1'b0);
    endtask

    //-------------------------------------------------------------------------
    // Test sequence
    //-------------------------------------------------------------------------
    initial begin
        logic [71:0] a_v;
        logic [71:0] b_v;
        logic [71:0] c_v;
        logic [11:0] t_v;
        int          kind;

        // ---- reset state ----
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check56("rst_data", tx_data, 56'h0);
        check1("rst_valid", tx_valid, 1'b0);
        check8("rst_drop", drop_cnt, 8'h00);
        check1("rst_busy", busy, 1'b0);
        rst_n    = 1'b1;
        run      = 1'b1;
        tx_ready = 1'b1;

        // ---- single ADS frame: latency, packing, one-cycle valid ----
        pulse(1'b1, 72'h000000_123456_ABCDEF, 1'b0, 12'h0);
        check1("t1_valid_at_capture", tx_valid, 1'b0);
        check1("t1_busy_pending", busy, 1'b1);
        @(negedge clk);
        check1("t1_valid_after_load", tx_valid, 1'b1);
        check56("t1_data", tx_data, 56'hA1_123456_ABCDEF);
        @(negedge clk);
        check1("t1_valid_one_cycle", tx_valid, 1'b0);
        check1("t1_busy_done", busy, 1'b0);
        $display("txn t1 single ADS word done");

        // ---- simultaneous ADS + touch ----
        do_reset();
        tx_ready = 1'b1;
        a_v = 72'hFFFFFF_AAAAAA_555555;
        pulse(1'b1, a_v, 1'b1, 12'h005);
        model_send_both(a_v, 12'h005);
        drain(2, 20, 1'b0);
        if (got.size() > 1) begin
            check56("t2_tch_literal", got[1], 56'hB2_0005_00_000001);
        end
        compare("t2_both");
        $display("txn t2 ADS+touch tie done");

        // ---- backpressure with three ADS frames ----
        do_reset();
        tx_ready = 1'b0;
        a_v = 72'h111111_0A0A0A_0B0B0B;
        b_v = 72'h222222_1C1C1C_1D1D1D;
        c_v = 72'h333333_2E2E2E_2F2F2F;
        pulse(1'b1, a_v, 1'b0, 12'h0);
        @(negedge clk);
        @(negedge clk);
        pulse(1'b1, b_v, 1'b0, 12'h0);
        @(negedge clk);
        @(negedge clk);
        pulse(1'b1, c_v, 1'b0, 12'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check1("t3_valid_stable", tx_valid, 1'b1);
            check56("t3_data_stable", tx_data, ads_word(a_v));
        end
        check8("t3_drop", drop_cnt, 8'h01);
        m_drop = 8'h01;
        model_send_ads(a_v);
        model_send_ads(c_v);
        drain(2, 20, 1'b0);
        compare("t3_backpressure");
        $display("txn t3 backpressure done");

        // ---- drop counter saturation ----
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ads_data  = {24'h0, 24'(i), ~24'(i)};
            ads_valid = 1'b1;
            @(negedge clk);
            if (i == 100) check8("t4_drop_100", drop_cnt, 8'd99);
            if (i == 256) check8("t4_drop_256", drop_cnt, 8'hFF);
            if (i == 257) check8("t4_drop_sat", drop_cnt, 8'hFF);
        end
        ads_valid = 1'b0;
        @(negedge clk);
        check8("t4_drop_final", drop_cnt, 8'hFF);
        check56("t4_first_held", tx_data, ads_word({24'h0, 24'd0, ~24'd0}));
        m_drop = 8'hFF;
        model_send_ads({24'h0, 24'd0, ~24'd0});
        model_send_ads({24'h0, 24'd299, ~24'd299});
        drain(2, 20, 1'b0);
        compare("t4_sat");
        $display("txn t4 drop saturation done");

        // ---- repeated identical touch status ----
        for (int k = 0; k < 3; k++) begin
            pulse(1'b0, 72'h0, 1'b1, 12'h003);
            model_send_tch(12'h003);
            drain(exp_q.size(), 12, 1'b0);
            compare("t5_touch_repeat");
            $display("txn t5 touch repeat %0d done", k);
        end

        // ---- i_RUN low: in-flight word completes, pendings flushed ----
        tx_ready = 1'b0;
        a_v = 72'h0_445566_778899;
        b_v = 72'h0_ABABAB_CDCDCD;
        c_v = 72'h0_121212_343434;
        pulse(1'b1, a_v, 1'b0, 12'h0);
        @(negedge clk);
        pulse(1'b1, b_v, 1'b1, 12'h0A5);
        run = 1'b0;
        @(negedge clk);
        check1("t6_valid_kept", tx_valid, 1'b1);
        check56("t6_data_kept", tx_data, ads_word(a_v));
        pulse(1'b1, c_v, 1'b1, 12'h05A);
        run = 1'b1;
        model_send_ads(a_v);
        drain(1, 20, 1'b0);
        compare("t6_run_low");
        $display("txn t6 run low done");

        // ---- randomized rounds ----
        do_reset();
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(1, 3);
            a_v  = {8'($urandom()), $urandom(), $urandom()};
            t_v  = ($urandom_range(0, 3) == 0) ? m_ref : 12'($urandom());
            pulse((kind & 1) != 0, a_v, (kind & 2) != 0, t_v);
            if (kind == 3) model_send_both(a_v, t_v);
            else if (kind == 1) model_send_ads(a_v);
            else model_send_tch(t_v);
            drain(exp_q.size(), 200, 1'b1);
            compare("rnd");
            $display("txn rnd %0d kind=%0d words=%0d", r, kind, got.size());
        end

        // ---- asynchronous reset while a word is valid ----
        tx_ready = 1'b0;
        pulse(1'b1, 72'h0_DEDEDE_ADADAD, 1'b0, 12'h0);
        @(negedge clk);
        check1("t8_valid_before", tx_valid, 1'b1);
        #5 rst_n = 1'b0;
        #1;
        check1("t8_valid_async", tx_valid, 1'b0);
        check1("t8_busy_async", busy, 1'b0);
        check56("t8_data_async", tx_data, 56'h0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn t8 async reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
